// File: rtl/move_log_fifo.sv
// Move log FIFO: stores face turns, merging consecutive turns of the same face.
// Turns that add up to a full rotation cancel and remove the tail entry.
module move_log_fifo #(
  parameter int DEPTH  = 32,
  parameter int FACE_W = 4,
  parameter int MERGE  = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         in_valid,
  input  logic [FACE_W-1:0]            in_face,
  input  logic [1:0]                   in_q,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [FACE_W-1:0]            out_face,
  output logic [1:0]                   out_q,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [FACE_W-1:0] face_mem [DEPTH];
  logic [1:0]        q_mem    [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic [PW-1:0] tail_ptr;
  logic          pop, push, tail_busy, merge_hit, cancel, upd_en, write_en;
  logic [1:0]    merge_q;

  // Decode push/pop/merge and compute the next pointer, count and flag values.
  always_comb begin
    pop       = (count_q != '0) && out_ready;
    push      = in_valid && (in_q != 2'd0);
    tail_ptr  = wr_ptr_q - PW'(1);
    // A tail that is also the head leaving this cycle cannot absorb a merge.
    tail_busy = (count_q == ONE_C) && pop;
    merge_hit = (MERGE != 0) && push && (count_q != '0) &&
                (face_mem[tail_ptr] == in_face) && !tail_busy;
    merge_q   = q_mem[tail_ptr] + in_q;
    cancel    = merge_hit && (merge_q == 2'd0);
    upd_en    = merge_hit && !cancel;
    write_en  = push && !merge_hit && ((count_q != DEPTH_C) || pop);

    wr_ptr_d   = wr_ptr_q + PW'(write_en) - PW'(cancel);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    count_d    = count_q + CW'(write_en) - CW'(cancel) - CW'(pop);
    overflow_d = overflow_q | (push && !merge_hit && (count_q == DEPTH_C) && !pop);

    if (clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      upd_en     = 1'b0;
      write_en   = 1'b0;
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage: new entries land at the write pointer, merges rewrite the tail turn.
  always_ff @(posedge clk) begin
    if (write_en) begin
      face_mem[wr_ptr_q] <= in_face;
      q_mem[wr_ptr_q]    <= in_q;
    end
    if (upd_en) begin
      q_mem[tail_ptr] <= merge_q;
    end
  end

  // Head is shown fall-through; outputs are forced to zero while empty.
  always_comb begin
    out_valid = (count_q != '0);
    out_face  = out_valid ? face_mem[rd_ptr_q] : '0;
    out_q     = out_valid ? q_mem[rd_ptr_q] : 2'd0;
    count     = count_q;
    full      = (count_q == DEPTH_C);
    overflow  = overflow_q;
  end

endmodule
